// File: rtl/fp_mem_sequencer.sv
// rtl/fp_mem_sequencer.sv - multi-word FP data-memory access sequencer
// Issues 1..MAX_WORDS consecutive single-port memory accesses and assembles load words.
module fp_mem_sequencer #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 7,
   parameter int MAX_WORDS = 2,
   parameter bit HI_FIRST  = 1'b1,
   localparam int NW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
   localparam int BW = DATA_W * MAX_WORDS
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_wr,
   input  logic [NW-1:0]     i_req_nm1,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [BW-1:0]     i_req_wdata,
   output logic              o_busy,
   output logic              o_rsp_valid,
   output logic [BW-1:0]     o_rsp_rdata,
   output logic              o_cen,
   output logic              o_wen,
   output logic              o_oen,
   output logic [ADDR_W-1:0] o_a,
   output logic [DATA_W-1:0] o_data2mem,
   input  logic [DATA_W-1:0] i_read_data_mem
);
   localparam int CW = $clog2(MAX_WORDS + 1);
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_LAST, S_DONE} state_t;

   state_t            r_state;
   logic              r_wr;
   logic [CW-1:0]     r_n;
   logic [CW-1:0]     r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [BW-1:0]     r_wdata;
   logic [CW-1:0]     w_n;
   logic [CW-1:0]     w_idx_nx;
   logic [ADDR_W-1:0] w_a_nx;

   // Word slot inside the wide bus that belongs to access number idx.
   function automatic logic [CW-1:0] f_slot(input logic [CW-1:0] idx, input logic [CW-1:0] n);
      return HI_FIRST ? (n - ONE - idx) : idx;
   endfunction

   always_comb begin
      w_n = CW'(MAX_WORDS);
      if (int'(i_req_nm1) < MAX_WORDS - 1) w_n = CW'(i_req_nm1) + ONE;
      w_idx_nx = r_idx + ONE;
      w_a_nx   = r_addr + ADDR_W'(w_idx_nx);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_wr        <= 1'b0;
         r_n         <= '0;
         r_idx       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         o_req_ready <= 1'b1;
         o_busy      <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_cen       <= 1'b1;
         o_wen       <= 1'b1;
         o_oen       <= 1'b1;
         o_a         <= '0;
         o_data2mem  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  r_state     <= S_XFER;
                  r_wr        <= i_req_wr;
                  r_n         <= w_n;
                  r_idx       <= '0;
                  r_addr      <= i_req_addr;
                  r_wdata     <= i_req_wdata;
                  o_rsp_rdata <= '0;
                  o_req_ready <= 1'b0;
                  o_busy      <= 1'b1;
                  o_cen       <= 1'b0;
                  o_wen       <= ~i_req_wr;
                  o_oen       <= i_req_wr;
                  o_a         <= i_req_addr;
                  o_data2mem  <= i_req_wr ? i_req_wdata[f_slot('0, w_n)*DATA_W +: DATA_W] : '0;
               end
            end
            S_XFER: begin
               // Read data arrives one cycle late, so this cycle returns the previous access.
               if (!r_wr && r_idx != '0)
                  o_rsp_rdata[f_slot(r_idx - ONE, r_n)*DATA_W +: DATA_W] <= i_read_data_mem;
               if (r_idx == r_n - ONE) begin
                  o_cen       <= 1'b1;
                  o_wen       <= 1'b1;
                  o_oen       <= 1'b1;
                  o_a         <= '0;
                  o_data2mem  <= '0;
                  o_rsp_valid <= r_wr;
                  r_state     <= r_wr ? S_DONE : S_LAST;
               end else begin
                  r_idx      <= w_idx_nx;
                  o_a        <= w_a_nx;
                  o_data2mem <= r_wr ? r_wdata[f_slot(w_idx_nx, r_n)*DATA_W +: DATA_W] : '0;
               end
            end
            S_LAST: begin
               o_rsp_rdata[f_slot(r_idx, r_n)*DATA_W +: DATA_W] <= i_read_data_mem;
               o_rsp_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               o_rsp_valid <= 1'b0;
               o_busy      <= 1'b0;
               o_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
